// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - PLIC interrupt gateway: synchronise, edge/level qualify, hold in service
//
// Purpose: turns each raw interrupt line into a single pending request for the
// register file, blocks re-requests while the source is in service, and counts
// edges that arrive during service so they are replayed after completion.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   src            raw asynchronous lines, bit k = source k+1
//   el             trigger mode per source (1 = edge), bit s = source s, bit 0 unused
//   ip             pending vector, bit k = source k+1, straight from state flops
//   claim/complete per-target one-cycle strobes qualified by id[t]
//   id             per-target source ID (0 = none)
//   edge_drop      one-cycle pulse when an edge is lost to a saturated counter

module plic_gateway #(
  parameter int SOURCES      = 8,
  parameter int SOURCES_BITS = 4,
  parameter int TARGETS      = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_EDGE_CNT = 7,
  parameter int CNT_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [SOURCES-1:0]      src,
  input  logic [SOURCES:0]        el,
  output logic [SOURCES-1:0]      ip,
  input  logic [TARGETS-1:0]      claim,
  input  logic [TARGETS-1:0]      complete,
  input  logic [SOURCES_BITS-1:0] id [TARGETS],
  output logic [SOURCES-1:0]      edge_drop
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    INSERV  = 2'd2
  } state_e;

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_EDGE_CNT);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [SOURCES-1:0]  sync_q [SYNC_STAGES];
  logic [SOURCES-1:0]  sync_d [SYNC_STAGES];
  logic [SOURCES-1:0]  s_prev_q, s_prev_d;
  logic [SOURCES-1:0]  s_sync, rise;
  logic [SOURCES-1:0]  claim_hit, complete_hit;
  logic [SOURCES-1:0]  drop_q, drop_d;
  state_e              state_q [SOURCES];
  state_e              state_d [SOURCES];
  logic [CNT_BITS-1:0] cnt_q [SOURCES];
  logic [CNT_BITS-1:0] cnt_d [SOURCES];

  // el[0] has no source attached.
  logic unused_el0;
  assign unused_el0 = el[0];

  // Synchroniser chain and rising-edge detect on the synchronised line.
  always_comb begin
    sync_d[0] = src;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s_sync   = sync_q[SYNC_STAGES-1];
  assign s_prev_d = s_sync;
  assign rise     = s_sync & ~s_prev_q;

  // Decode strobes into per-source hits. ID 0 and out-of-range IDs never
  // match any source, so they are ignored without extra logic. Several
  // targets hitting the same source collapse into one hit.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int k = 0; k < SOURCES; k++) begin
      for (int t = 0; t < TARGETS; t++) begin
        if (claim[t] && (id[t] == SOURCES_BITS'(k + 1))) begin
          claim_hit[k] = 1'b1;
        end
        if (complete[t] && (id[t] == SOURCES_BITS'(k + 1))) begin
          complete_hit[k] = 1'b1;
        end
      end
    end
  end

  // Per-source FSM and deferred-edge counter.
  always_comb begin
    drop_d = '0;
    for (int k = 0; k < SOURCES; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];

      case (state_q[k])
        IDLE: begin
          if (el[k+1]) begin
            // A fresh edge takes priority; stored edges wait for the next round.
            if (rise[k]) begin
              state_d[k] = PENDING;
            end else if (cnt_q[k] != '0) begin
              state_d[k] = PENDING;
              cnt_d[k]   = cnt_q[k] - CNT_ONE;
            end
          end else if (s_sync[k]) begin
            state_d[k] = PENDING;
          end
        end
        PENDING: begin
          if (claim_hit[k]) begin
            state_d[k] = INSERV;
          end
        end
        INSERV: begin
          if (complete_hit[k]) begin
            state_d[k] = IDLE;
          end
        end
        default: state_d[k] = IDLE;
      endcase

      // Edges seen while the source is busy are banked for later replay.
      if (el[k+1] && (state_q[k] != IDLE) && rise[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          drop_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end

      if (!el[k+1]) begin
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      s_prev_q <= '0;
      drop_q   <= '0;
      for (int k = 0; k < SOURCES; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      s_prev_q <= s_prev_d;
      drop_q   <= drop_d;
      for (int k = 0; k < SOURCES; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    ip = '0;
    for (int k = 0; k < SOURCES; k++) begin
      ip[k] = (state_q[k] == PENDING);
    end
  end

  assign edge_drop = drop_q;

endmodule

// File: tb/tb_plic_gateway.sv
// tb/tb_plic_gateway.sv - directed bench for plic_gateway
module tb_plic_gateway;

  localparam int SOURCES = 8;
  localparam int SB      = 4;
  localparam int TARGETS = 2;
  localparam int MAXC    = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic [SOURCES-1:0] src;
  logic [SOURCES:0]   el;
  logic [SOURCES-1:0] ip;
  logic [TARGETS-1:0] claim;
  logic [TARGETS-1:0] complete;
  logic [SB-1:0]      id [TARGETS];
  logic [SOURCES-1:0] edge_drop;

  int total = 0;
  int bad   = 0;
  int drop_cnt = 0;

  plic_gateway #(
    .SOURCES(SOURCES), .SOURCES_BITS(SB), .TARGETS(TARGETS),
    .SYNC_STAGES(2), .MAX_EDGE_CNT(MAXC), .CNT_BITS(3)
  ) dut (
    .clk(clk), .rstn(rstn), .src(src), .el(el), .ip(ip),
    .claim(claim), .complete(complete), .id(id), .edge_drop(edge_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (edge_drop[1] === 1'b1) drop_cnt = drop_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [1:0] c, input logic [1:0] p,
                        input logic [SB-1:0] i0, input logic [SB-1:0] i1);
    claim = c; complete = p; id[0] = i0; id[1] = i1;
    cyc(1);
    claim = '0; complete = '0; id[0] = '0; id[1] = '0;
  endtask

  task automatic pulse(input int b);
    src[b] = 1'b1;
    cyc(1);
    src[b] = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; src = '0; claim = '0; complete = '0; id[0] = '0; id[1] = '0;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
  endtask

  initial begin
    rstn = 1'b0; src = '0; claim = '0; complete = '0; id[0] = '0; id[1] = '0;
    el = 9'b0_0000_0110;  // sources 1 and 2 edge, rest level
    #1;
    chk("rst_ip", 32'(ip), 32'h0);
    chk("rst_drop", 32'(edge_drop), 32'h0);
    cyc(2);
    rstn = 1'b1;
    cyc(1);

    // Level source 3
    src[2] = 1'b1;
    cyc(1); chk("lvl_e0", 32'(ip[2]), 32'd0);
    cyc(1); chk("lvl_e1", 32'(ip[2]), 32'd0);
    cyc(1); chk("lvl_e2", 32'(ip[2]), 32'd1);
    strobe(2'b01, 2'b00, 4'd3, 4'd0);
    chk("lvl_claim", 32'(ip[2]), 32'd0);
    strobe(2'b00, 2'b01, 4'd3, 4'd0);
    chk("lvl_idle", 32'(ip[2]), 32'd0);
    cyc(1); chk("lvl_repend", 32'(ip[2]), 32'd1);
    src[2] = 1'b0;
    cyc(4); chk("lvl_latched", 32'(ip[2]), 32'd1);
    strobe(2'b01, 2'b00, 4'd3, 4'd0);
    strobe(2'b00, 2'b01, 4'd3, 4'd0);
    cyc(3); chk("lvl_gone", 32'(ip), 32'h0);

    // Edge counting on source 1
    do_reset();
    pulse(0);
    cyc(1); chk("edg_pend", 32'(ip[0]), 32'd1);
    strobe(2'b01, 2'b00, 4'd1, 4'd0);
    chk("edg_claim", 32'(ip[0]), 32'd0);
    for (int i = 0; i < 3; i++) pulse(0);
    cyc(2); chk("edg_held", 32'(ip[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(2'b00, 2'b01, 4'd1, 4'd0);
      chk("edg_idle", 32'(ip[0]), 32'd0);
      cyc(1); chk("edg_repend", 32'(ip[0]), 32'd1);
      strobe(2'b01, 2'b00, 4'd1, 4'd0);
    end
    strobe(2'b00, 2'b01, 4'd1, 4'd0);
    cyc(3); chk("edg_empty", 32'(ip[0]), 32'd0);

    // Saturation on source 2 (MAX_EDGE_CNT = 3)
    do_reset();
    pulse(1);
    cyc(1); chk("sat_pend", 32'(ip[1]), 32'd1);
    strobe(2'b01, 2'b00, 4'd2, 4'd0);
    drop_cnt = 0;
    for (int i = 0; i < 5; i++) pulse(1);
    cyc(3); chk("sat_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      strobe(2'b00, 2'b01, 4'd2, 4'd0);
      cyc(1); chk("sat_repend", 32'(ip[1]), 32'd1);
      strobe(2'b01, 2'b00, 4'd2, 4'd0);
    end
    strobe(2'b00, 2'b01, 4'd2, 4'd0);
    cyc(3); chk("sat_empty", 32'(ip[1]), 32'd0);
    chk("sat_drops_end", 32'(drop_cnt), 32'd2);

    // Ignored strobes
    do_reset();
    strobe(2'b01, 2'b00, 4'd5, 4'd0);
    cyc(1); chk("bad_claim_idle", 32'(ip), 32'h0);
    src[4] = 1'b1;
    cyc(3); chk("bad_src5_pends", 32'(ip[4]), 32'd1);
    src[2] = 1'b1;
    cyc(3); chk("bad_src3_pends", 32'(ip[2]), 32'd1);
    strobe(2'b00, 2'b01, 4'd3, 4'd0);
    cyc(2); chk("bad_cmpl_pend", 32'(ip[2]), 32'd1);
    strobe(2'b11, 2'b00, 4'd0, 4'd0);
    chk("bad_id0", 32'(ip), 32'h14);
    strobe(2'b11, 2'b00, 4'd11, 4'd13);
    chk("bad_id_hi", 32'(ip), 32'h14);

    // Multi-target on source 4
    do_reset();
    src[3] = 1'b1;
    cyc(3); chk("mt_pend", 32'(ip[3]), 32'd1);
    strobe(2'b11, 2'b00, 4'd4, 4'd4);
    chk("mt_claim", 32'(ip[3]), 32'd0);
    strobe(2'b00, 2'b10, 4'd0, 4'd4);
    chk("mt_idle", 32'(ip[3]), 32'd0);
    cyc(1); chk("mt_repend", 32'(ip[3]), 32'd1);
    strobe(2'b01, 2'b10, 4'd4, 4'd4);
    cyc(3); chk("mt_same_cyc", 32'(ip[3]), 32'd0);
    strobe(2'b00, 2'b01, 4'd4, 4'd0);
    cyc(1); chk("mt_cmpl_t0", 32'(ip[3]), 32'd1);

    // Reset mid-service
    do_reset();
    pulse(0);
    cyc(1);
    strobe(2'b01, 2'b00, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) pulse(0);
    src[2] = 1'b1;
    cyc(3); chk("rst_pre", 32'(ip), 32'h04);
    rstn = 1'b0;
    #1; chk("rst_async", 32'(ip), 32'h0);
    #4; rstn = 1'b1;
    cyc(1); chk("rst_e0", 32'(ip), 32'h0);
    cyc(1); chk("rst_e1", 32'(ip), 32'h0);
    cyc(1); chk("rst_repend", 32'(ip), 32'h04);
    strobe(2'b00, 2'b01, 4'd1, 4'd0);
    cyc(2); chk("rst_cnt_clear", 32'(ip), 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
